// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: the in-flight entry record and
// the EX forward-select encoding.
package pipe_hazard_scoreboard_pkg;

    // The entry dst field is sized for the widest register file we build.
    // Narrower REG_AW values are zero-extended into it.
    localparam int HZ_DST_W = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                valid;
        logic [HZ_DST_W-1:0] dst;
        logic                load;
    } hz_entry_t;

    // The youngest producer wins: EX/MEM takes priority over MEM/WB.
    function automatic fwd_sel_e fwd_pick(input logic m0, input logic m1);
        if (m0) return FWD_EXMEM;
        if (m1) return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-stage <-> hazard unit signal bundle.
// The master side is the decode stage. The slave side is the scoreboard.
interface pipe_hazard_scoreboard_if #(parameter int REG_AW = 5);
    logic              issue_valid_i;
    logic [REG_AW-1:0] src_a_i;
    logic [REG_AW-1:0] src_b_i;
    logic              use_b_i;
    logic [REG_AW-1:0] dst_i;
    logic              reg_write_i;
    logic              mem_read_i;
    logic              flush_i;
    logic              stall_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;

    modport master (
        output issue_valid_i, src_a_i, src_b_i, use_b_i, dst_i,
               reg_write_i, mem_read_i, flush_i,
        input  stall_o, fwd_a_o, fwd_b_o
    );

    modport slave (
        input  issue_valid_i, src_a_i, src_b_i, use_b_i, dst_i,
               reg_write_i, mem_read_i, flush_i,
        output stall_o, fwd_a_o, fwd_b_o
    );
endinterface

// File: rtl/pipe_hazard_scoreboard_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counts.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Increment unless already pinned at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + WIDTH'(1);
    end

    // Counter register; the reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// RAW hazard scoreboard for the 5-stage pipeline.
// It tracks in-flight register writes from EX to WB. It produces a
// combinational stall for ID and registered forward selects for EX.
// It also squashes young entries on a taken-branch flush.
module pipe_hazard_scoreboard
    import pipe_hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int DEPTH         = 3,
    parameter bit FWD_EN        = 1'b1,
    parameter bit RF_WR_THRU    = 1'b0,
    parameter int FLUSH_ENTRIES = 1,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    pipe_hazard_scoreboard_if.slave  hz,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         flush_cnt_o
);
    hz_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic      [DEPTH-1:0] match_a, match_b, hit;
    logic [HZ_DST_W-1:0]   src_a_x, src_b_x, dst_x;
    logic                  stall, issue_go;
    fwd_sel_e              fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    assign src_a_x = HZ_DST_W'(hz.src_a_i);
    assign src_b_x = HZ_DST_W'(hz.src_b_i);
    assign dst_x   = HZ_DST_W'(hz.dst_i);

    // Compare each entry against both operands. Then decide per entry
    // whether a match stalls or is left to the forwarding network.
    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        assign match_a[k] = ent_q[k].valid && (ent_q[k].dst == src_a_x) && (src_a_x != '0);
        assign match_b[k] = hz.use_b_i && ent_q[k].valid &&
                            (ent_q[k].dst == src_b_x) && (src_b_x != '0);
        if (RF_WR_THRU && (k == DEPTH-1)) begin : g_thru
            // The regfile writes through, so a WB producer is already visible.
            assign hit[k] = 1'b0;
        end else if (FWD_EN && (k == 0)) begin : g_ex
            // Load data is not ready at the end of EX: only load-use stalls.
            assign hit[k] = (match_a[k] | match_b[k]) & ent_q[k].load;
        end else if (FWD_EN && (k == 1)) begin : g_mem
            assign hit[k] = 1'b0;
        end else begin : g_old
            assign hit[k] = match_a[k] | match_b[k];
        end
    end

    assign stall    = hz.issue_valid_i & (|hit);
    assign issue_go = hz.issue_valid_i & ~stall & ~hz.flush_i;

    // Shift the entries toward WB and load the ID instruction into EX.
    // A stall or a flush puts a bubble into EX instead, and a flush also
    // kills the youngest entries that are already in flight.
    always_comb begin
        ent_d          = '0;
        ent_d[0].valid = issue_go & hz.reg_write_i & (dst_x != '0);
        ent_d[0].dst   = dst_x;
        ent_d[0].load  = hz.mem_read_i;
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
            if (hz.flush_i && (k <= FLUSH_ENTRIES)) ent_d[k].valid = 1'b0;
        end
    end

    // Forward selects travel with the instruction into EX; bubbles carry 00.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (FWD_EN && issue_go) begin
            fwd_a_d = fwd_pick(match_a[0], match_a[1]);
            fwd_b_d = fwd_pick(match_b[0], match_b[1]);
        end
    end

    // Scoreboard and forward-select registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q   <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            ent_q   <= ent_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign hz.stall_o = stall;
    assign hz.fwd_a_o = fwd_a_q;
    assign hz.fwd_b_o = fwd_b_q;

    // A cycle that has both a stall and a flush counts only as a flush.
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall & ~hz.flush_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (hz.flush_i),
        .cnt_o (flush_cnt_o)
    );
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard.
// dut1 runs with forwarding enabled, dut0 without it, and dut2 has a
// 2-bit counter width. The sel signal routes issue and flush to one DUT.
module tb_pipe_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [1:0] sel;
    logic       iv, ub, rw, mr, fl;
    logic [4:0] sa, sb, dd;

    pipe_hazard_scoreboard_if #(.REG_AW(5)) if0 ();
    pipe_hazard_scoreboard_if #(.REG_AW(5)) if1 ();
    pipe_hazard_scoreboard_if #(.REG_AW(5)) if2 ();

    assign if0.issue_valid_i = iv && (sel == 2'd0);
    assign if0.flush_i       = fl && (sel == 2'd0);
    assign if0.src_a_i = sa; assign if0.src_b_i = sb; assign if0.use_b_i = ub;
    assign if0.dst_i = dd;   assign if0.reg_write_i = rw; assign if0.mem_read_i = mr;

    assign if1.issue_valid_i = iv && (sel == 2'd1);
    assign if1.flush_i       = fl && (sel == 2'd1);
    assign if1.src_a_i = sa; assign if1.src_b_i = sb; assign if1.use_b_i = ub;
    assign if1.dst_i = dd;   assign if1.reg_write_i = rw; assign if1.mem_read_i = mr;

    assign if2.issue_valid_i = iv && (sel == 2'd2);
    assign if2.flush_i       = fl && (sel == 2'd2);
    assign if2.src_a_i = sa; assign if2.src_b_i = sb; assign if2.use_b_i = ub;
    assign if2.dst_i = dd;   assign if2.reg_write_i = rw; assign if2.mem_read_i = mr;

    logic [31:0] s0, f0, s1, f1;
    logic [1:0]  s2, f2;

    pipe_hazard_scoreboard #(.FWD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .hz(if0), .stall_cnt_o(s0), .flush_cnt_o(f0));
    pipe_hazard_scoreboard #(.FWD_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .hz(if1), .stall_cnt_o(s1), .flush_cnt_o(f1));
    pipe_hazard_scoreboard #(.FWD_EN(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .hz(if2), .stall_cnt_o(s2), .flush_cnt_o(f2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic u, input logic [4:0] d, input logic w, input logic m);
        iv = v; sa = a; sb = b; ub = u; dd = d; rw = w; mr = m;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        fl = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", if1.stall_o); end
        checks++; if (if1.fwd_a_o !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got=%0b exp=00", if1.fwd_a_o); end
        checks++; if (if1.fwd_b_o !== 2'b00) begin errors++; $display("FAIL reset_fwd_b got=%0b exp=00", if1.fwd_b_o); end
        checks++; if (s1 !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", s1); end
        checks++; if (f1 !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt got=%0d exp=0", f1); end
        checks++; if (s0 !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt0 got=%0d exp=0", s0); end
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5
    task automatic test_alu_b2b();
        sel = 2'd1;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); #1;
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_prod got=%0b exp=0", if1.stall_o); end
        tick();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0); #1;
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall got=%0b exp=0", if1.stall_o); end
        tick();
        checks++; if (if1.fwd_a_o !== 2'b01) begin errors++; $display("FAIL b2b_fwd_a got=%0b exp=01", if1.fwd_a_o); end
        checks++; if (if1.fwd_b_o !== 2'b00) begin errors++; $display("FAIL b2b_fwd_b got=%0b exp=00", if1.fwd_b_o); end
        idle(4);
    endtask

    // add $7 ; nop ; and $8,$7,$0
    task automatic test_alu_gap();
        sel = 2'd1;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0); #1;
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL gap_stall got=%0b exp=0", if1.stall_o); end
        tick();
        checks++; if (if1.fwd_a_o !== 2'b10) begin errors++; $display("FAIL gap_fwd_a got=%0b exp=10", if1.fwd_a_o); end
        checks++; if (if1.fwd_b_o !== 2'b00) begin errors++; $display("FAIL gap_fwd_b got=%0b exp=00", if1.fwd_b_o); end
        idle(4);
    endtask

    // lw $2,0($9) ; add $6,$2,$2
    task automatic test_load_use();
        sel = 2'd1;
        set_id(1'b1, 5'd9, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0); #1;
        checks++; if (if1.stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", if1.stall_o); end
        tick();
        checks++; if (if1.fwd_a_o !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd got=%0b exp=00", if1.fwd_a_o); end
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got=%0b exp=0", if1.stall_o); end
        tick();
        checks++; if (if1.fwd_a_o !== 2'b10) begin errors++; $display("FAIL lu_fwd_a got=%0b exp=10", if1.fwd_a_o); end
        checks++; if (if1.fwd_b_o !== 2'b10) begin errors++; $display("FAIL lu_fwd_b got=%0b exp=10", if1.fwd_b_o); end
        checks++; if (s1 !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", s1); end
        idle(4);
    endtask

    // Without forwarding, a back-to-back dependence waits out all three entries.
    task automatic test_nofwd();
        int n;
        sel = 2'd0;
        n = 0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0); #1;
        for (int i = 0; i < 10; i++) begin
            if (if0.stall_o !== 1'b1) break;
            n++;
            checks++; if (if0.fwd_a_o !== 2'b00) begin errors++; $display("FAIL nofwd_bubble_fwd got=%0b exp=00", if0.fwd_a_o); end
            tick();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL nofwd_stall_cycles got=%0d exp=3", n); end
        tick();
        checks++; if (if0.fwd_a_o !== 2'b00) begin errors++; $display("FAIL nofwd_fwd_a got=%0b exp=00", if0.fwd_a_o); end
        checks++; if (s0 !== 32'd3) begin errors++; $display("FAIL nofwd_stall_cnt got=%0d exp=3", s0); end
        idle(4);
    endtask

    task automatic test_zero_and_use_b();
        sel = 2'd0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0); #1;
        checks++; if (if0.stall_o !== 1'b0) begin errors++; $display("FAIL zero_reg_stall got=%0b exp=0", if0.stall_o); end
        idle(4);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd5, 1'b0, 5'd9, 1'b0, 1'b0); #1;
        checks++; if (if0.stall_o !== 1'b0) begin errors++; $display("FAIL use_b0_stall got=%0b exp=0", if0.stall_o); end
        ub = 1'b1; #1;
        checks++; if (if0.stall_o !== 1'b1) begin errors++; $display("FAIL use_b1_stall got=%0b exp=1", if0.stall_o); end
        iv = 1'b0;
        idle(4);
        checks++; if (s0 !== 32'd3) begin errors++; $display("FAIL use_b_stall_cnt got=%0d exp=3", s0); end
    endtask

    // A flush with the load in EX and its dependent in ID.
    task automatic test_flush();
        sel = 2'd1;
        set_id(1'b1, 5'd9, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        fl = 1'b1; #1;
        checks++; if (if1.stall_o !== 1'b1) begin errors++; $display("FAIL flush_comb_stall got=%0b exp=1", if1.stall_o); end
        tick();
        fl = 1'b0; #1;
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL flush_next_stall got=%0b exp=0", if1.stall_o); end
        checks++; if (f1 !== 32'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", f1); end
        checks++; if (s1 !== 32'd1) begin errors++; $display("FAIL flush_stall_cnt got=%0d exp=1", s1); end
        tick();
        checks++; if (if1.fwd_a_o !== 2'b00) begin errors++; $display("FAIL flush_fwd_a got=%0b exp=00", if1.fwd_a_o); end
        checks++; if (if1.fwd_b_o !== 2'b00) begin errors++; $display("FAIL flush_fwd_b got=%0b exp=00", if1.fwd_b_o); end
        idle(4);
    endtask

    task automatic test_back_to_back();
        sel = 2'd1;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd10, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0); #1;
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL chain_stall got=%0b exp=0", if1.stall_o); end
        tick();
        checks++; if (if1.fwd_a_o !== 2'b01) begin errors++; $display("FAIL chain1_fwd_a got=%0b exp=01", if1.fwd_a_o); end
        set_id(1'b1, 5'd11, 5'd10, 1'b1, 5'd12, 1'b1, 1'b0);
        tick();
        checks++; if (if1.fwd_a_o !== 2'b01) begin errors++; $display("FAIL chain2_fwd_a got=%0b exp=01", if1.fwd_a_o); end
        checks++; if (if1.fwd_b_o !== 2'b10) begin errors++; $display("FAIL chain2_fwd_b got=%0b exp=10", if1.fwd_b_o); end
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
        tick();
        tick();
        set_id(1'b1, 5'd13, 5'd0, 1'b1, 5'd14, 1'b1, 1'b0);
        tick();
        checks++; if (if1.fwd_a_o !== 2'b01) begin errors++; $display("FAIL youngest_fwd_a got=%0b exp=01", if1.fwd_a_o); end
        idle(4);
    endtask

    task automatic test_saturate();
        sel = 2'd2;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        fl = 1'b1;
        repeat (5) tick();
        fl = 1'b0;
        checks++; if (f2 !== 2'd3) begin errors++; $display("FAIL sat_flush_cnt got=%0d exp=3", f2); end
        checks++; if (s2 !== 2'd0) begin errors++; $display("FAIL sat_stall_cnt got=%0d exp=0", s2); end
        checks++; if (f1 !== 32'd1) begin errors++; $display("FAIL sat_other_flush_cnt got=%0d exp=1", f1); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        sel = 2'd1;
        set_id(1'b1, 5'd9, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd2, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        checks++; if (if1.fwd_a_o !== 2'b01) begin errors++; $display("FAIL pre_rst_fwd_a got=%0b exp=01", if1.fwd_a_o); end
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); #1;
        checks++; if (if1.stall_o !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got=%0b exp=1", if1.stall_o); end
        rst = 1'b0; #1;
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", if1.stall_o); end
        checks++; if (if1.fwd_a_o !== 2'b00) begin errors++; $display("FAIL rst_fwd_a got=%0b exp=00", if1.fwd_a_o); end
        checks++; if (s1 !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", s1); end
        checks++; if (f1 !== 32'd0) begin errors++; $display("FAIL rst_flush_cnt got=%0d exp=0", f1); end
        tick();
        rst = 1'b1; #1;
        checks++; if (if1.stall_o !== 1'b0) begin errors++; $display("FAIL post_rst_stall got=%0b exp=0", if1.stall_o); end
        tick();
        checks++; if (if1.fwd_a_o !== 2'b00) begin errors++; $display("FAIL post_rst_fwd_a got=%0b exp=00", if1.fwd_a_o); end
        checks++; if (s1 !== 32'd0) begin errors++; $display("FAIL post_rst_stall_cnt got=%0d exp=0", s1); end
        idle(2);
    endtask

    initial begin
        sel = 2'd1;
        fl  = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        test_reset();
        test_alu_b2b();
        test_alu_gap();
        test_load_use();
        test_nofwd();
        test_zero_and_use_b();
        test_flush();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
